fast_pat_fetch_multi: RTL and testbench

- Parametrised successor to the single-pattern fast fetcher.
- Streams a sequence of stored DMD patterns from on-chip memory into the HDMI pixel path, one pattern per frame.
- Supports binary (1 bpp) and grayscale (8 bpp) packing, plus a configurable pattern count and stride.
- Sits between the DMD-specific video timing generator (hsync/vsync/de in HDMI format) and the HDMI transmitter; a prefetch FIFO decouples memory reads from the de timing.

---
 rtl/fast_pat_pkg.sv | 21 ++
 rtl/fast_pat_fifo.sv | 53 +++++
 rtl/fast_pat_fetch_multi.sv | 232 +++++++++++++++++++++++
 tb/tb_fast_pat_fetch_multi.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_pat_pkg.sv
// Shared types and helpers for the multi-pattern DMD fetcher.
// Holds the FSM state encoding, the pixel packing modes and the words-per-line math.
package fast_pat_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_WAIT_VS,
    S_STREAM,
    S_FRAME_END
  } state_t;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  // Memory words needed to hold one active line at the given bits per pixel.
  function automatic int calc_wpl(input int line_pix, input int bpp, input int mem_dw);
    return (line_pix * bpp + mem_dw - 1) / mem_dw;
  endfunction

endpackage

// File: rtl/fast_pat_fifo.sv
// Synchronous prefetch FIFO with occupancy count and a single-cycle flush.
// Pushes while full and pops while empty are ignored.
module fast_pat_fifo #(
  parameter int DW    = 256,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fast_pat_fetch_multi.sv
// Streams a sequence of stored DMD patterns from on-chip memory into the HDMI pixel path,
// one pattern per frame, unpacking 1 bpp or 8 bpp words LSB-first against the incoming de.
module fast_pat_fetch_multi
  import fast_pat_pkg::*;
#(
  parameter int MEM_DW     = 256,
  parameter int MEM_AW     = 11,
  parameter int PIX_W      = 24,
  parameter int LINE_PIX   = 1920,
  parameter int LINES      = 1080,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_PAT    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         onchip_mem_chip_select,
  output logic                         onchip_mem_chip_read,
  output logic [MEM_AW-1:0]            onchip_mem_addr,
  output logic [MEM_DW/8-1:0]          onchip_mem_byte_enable,
  output logic                         onchip_mem_write,
  output logic [MEM_DW-1:0]            onchip_mem_write_data,
  input  logic [MEM_DW-1:0]            onchip_mem_read_data,
  input  logic                         cfg_mode,
  input  logic [MEM_AW-1:0]            cfg_base_addr,
  input  logic [MEM_AW-1:0]            cfg_pat_stride,
  input  logic [$clog2(MAX_PAT):0]     cfg_num_pat,
  input  logic                         frame_trig,
  input  logic                         stop_req,
  output logic                         frame_busy,
  input  logic                         h_sync_in,
  input  logic                         v_sync_in,
  input  logic                         de_in,
  output logic [PIX_W-1:0]             pix_data_out,
  output logic                         h_sync_out,
  output logic                         v_sync_out,
  output logic                         de_out,
  output logic [$clog2(MAX_PAT)-1:0]   pat_idx,
  output logic                         underflow
);

  localparam int PPW_BIN  = MEM_DW;
  localparam int PPW_GRAY = MEM_DW / 8;
  localparam int TOT_BIN  = calc_wpl(LINE_PIX, 1, MEM_DW) * LINES;
  localparam int TOT_GRAY = calc_wpl(LINE_PIX, 8, MEM_DW) * LINES;
  localparam int TOT_W    = $clog2(TOT_GRAY + 1);
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int PC_W     = $clog2(MEM_DW);
  localparam int PB_W     = $clog2(MEM_DW / 8);
  localparam int LN_W     = $clog2(LINES + 1);
  localparam int NP_W     = $clog2(MAX_PAT) + 1;

  state_t state, state_n;

  logic                 mode_q;
  logic [MEM_AW-1:0]    base_q;
  logic [MEM_AW-1:0]    stride_q;
  logic [NP_W-1:0]      num_pat_q;
  logic [MEM_AW-1:0]    rd_addr;
  logic [TOT_W-1:0]     words_left;
  logic                 rd_pending;
  logic [PC_W-1:0]      pix_cnt;
  logic [LN_W-1:0]      lines_done;
  logic                 stop_seen;
  logic                 trig_q, vs_q, de_q;

  logic                 trig_rise, vs_rise, de_fall;
  logic                 fetching, rd_en, push, pop, flush, last_pat;
  logic [PC_W-1:0]      ppw_last;
  logic [MEM_DW-1:0]    fifo_dout;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full, fifo_empty;
  logic [MEM_DW/8-1:0][7:0] word_bytes;
  logic [PIX_W-1:0]     pix_value;

  assign trig_rise = frame_trig && !trig_q;
  assign vs_rise   = v_sync_in && !vs_q;
  assign de_fall   = de_q && !de_in;

  // Reads never exceed what the FIFO can absorb, counting the word still in flight.
  assign fetching = (state == S_PREFETCH) || (state == S_WAIT_VS) || (state == S_STREAM);
  assign rd_en    = fetching && (words_left != '0)
                 && ((fifo_count + CNT_W'(rd_pending)) < CNT_W'(FIFO_DEPTH));
  // Data returning while the FIFO is being flushed belongs to the old pattern.
  assign push     = rd_pending && (state != S_FRAME_END);
  assign last_pat = stop_seen || (NP_W'(pat_idx) == num_pat_q - 1'b1);

  assign ppw_last   = mode_q ? PC_W'(PPW_GRAY - 1) : PC_W'(PPW_BIN - 1);
  assign word_bytes = fifo_dout;
  assign pix_value  = mode_q ? {(PIX_W/8){word_bytes[pix_cnt[PB_W-1:0]]}}
                             : {PIX_W{fifo_dout[pix_cnt]}};

  assign onchip_mem_chip_select = rd_en;
  assign onchip_mem_chip_read   = rd_en;
  assign onchip_mem_addr        = rd_addr;
  assign onchip_mem_byte_enable = '1;
  assign onchip_mem_write       = 1'b0;
  assign onchip_mem_write_data  = '0;
  assign frame_busy             = (state != S_IDLE);
  assign v_sync_out             = vs_q;
  assign de_out                 = de_q;

  fast_pat_fifo #(
    .DW    (MEM_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (onchip_mem_read_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state)
      S_IDLE: begin
        if (trig_rise) begin
          state_n = S_PREFETCH;
          flush   = 1'b1;
        end
      end
      S_PREFETCH: begin
        if (fifo_full || (words_left == '0 && !rd_pending)) state_n = S_WAIT_VS;
      end
      S_WAIT_VS: begin
        if (vs_rise) state_n = S_STREAM;
      end
      S_STREAM: begin
        if (de_in) begin
          pop = (pix_cnt == ppw_last);
        end else if (de_fall) begin
          // Drop the unused tail so the next line starts on a word boundary.
          pop = (pix_cnt != '0);
          if (lines_done == LN_W'(LINES - 1)) state_n = S_FRAME_END;
        end
      end
      S_FRAME_END: begin
        flush   = 1'b1;
        state_n = last_pat ? S_IDLE : S_PREFETCH;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_BIN;
      base_q       <= '0;
      stride_q     <= '0;
      num_pat_q    <= '0;
      pat_idx      <= '0;
      rd_addr      <= '0;
      words_left   <= '0;
      rd_pending   <= 1'b0;
      pix_cnt      <= '0;
      lines_done   <= '0;
      stop_seen    <= 1'b0;
      underflow    <= 1'b0;
      trig_q       <= 1'b0;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      h_sync_out   <= 1'b0;
      pix_data_out <= '0;
    end else begin
      trig_q       <= frame_trig;
      vs_q         <= v_sync_in;
      de_q         <= de_in;
      h_sync_out   <= h_sync_in;
      rd_pending   <= rd_en;
      pix_data_out <= (state == S_STREAM && de_in && !fifo_empty) ? pix_value : '0;

      if (rd_en) begin
        rd_addr    <= rd_addr + 1'b1;
        words_left <= words_left - 1'b1;
      end
      if (state != S_IDLE && stop_req) stop_seen <= 1'b1;

      case (state)
        S_IDLE: begin
          if (trig_rise) begin
            mode_q     <= cfg_mode;
            base_q     <= cfg_base_addr;
            stride_q   <= cfg_pat_stride;
            num_pat_q  <= (cfg_num_pat == '0) ? NP_W'(1) : cfg_num_pat;
            pat_idx    <= '0;
            underflow  <= 1'b0;
            stop_seen  <= 1'b0;
            rd_addr    <= cfg_base_addr;
            words_left <= (cfg_mode == MODE_GRAY) ? TOT_W'(TOT_GRAY) : TOT_W'(TOT_BIN);
            pix_cnt    <= '0;
            lines_done <= '0;
          end
        end
        S_STREAM: begin
          if (de_in) begin
            // An empty FIFO still advances the stream position by one pixel.
            if (fifo_empty) underflow <= 1'b1;
            pix_cnt <= (pix_cnt == ppw_last) ? '0 : pix_cnt + 1'b1;
          end else if (de_fall) begin
            pix_cnt    <= '0;
            lines_done <= lines_done + 1'b1;
          end
        end
        S_FRAME_END: begin
          if (!last_pat) begin
            pat_idx    <= pat_idx + 1'b1;
            base_q     <= base_q + stride_q;
            rd_addr    <= base_q + stride_q;
            words_left <= (mode_q == MODE_GRAY) ? TOT_W'(TOT_GRAY) : TOT_W'(TOT_BIN);
            pix_cnt    <= '0;
            lines_done <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_pat_fetch_multi.sv
// Directed bench for fast_pat_fetch_multi: small frame geometry, behavioural 1-cycle memory,
// hand-computed pixel expectations captured from the delayed de/pixel outputs.
module tb_fast_pat_fetch_multi;

  localparam int MEM_DW     = 32;
  localparam int MEM_AW     = 11;
  localparam int PIX_W      = 24;
  localparam int LINE_PIX   = 16;
  localparam int LINES      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_PAT    = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                onchip_mem_chip_select;
  logic                onchip_mem_chip_read;
  logic [MEM_AW-1:0]   onchip_mem_addr;
  logic [MEM_DW/8-1:0] onchip_mem_byte_enable;
  logic                onchip_mem_write;
  logic [MEM_DW-1:0]   onchip_mem_write_data;
  logic [MEM_DW-1:0]   onchip_mem_read_data;
  logic                cfg_mode;
  logic [MEM_AW-1:0]   cfg_base_addr;
  logic [MEM_AW-1:0]   cfg_pat_stride;
  logic [4:0]          cfg_num_pat;
  logic                frame_trig;
  logic                stop_req;
  logic                frame_busy;
  logic                h_sync_in, v_sync_in, de_in;
  logic [PIX_W-1:0]    pix_data_out;
  logic                h_sync_out, v_sync_out, de_out;
  logic [3:0]          pat_idx;
  logic                underflow;

  fast_pat_fetch_multi #(
    .MEM_DW(MEM_DW), .MEM_AW(MEM_AW), .PIX_W(PIX_W), .LINE_PIX(LINE_PIX),
    .LINES(LINES), .FIFO_DEPTH(FIFO_DEPTH), .MAX_PAT(MAX_PAT)
  ) dut (
    .clk(clk), .rst(rst),
    .onchip_mem_chip_select(onchip_mem_chip_select),
    .onchip_mem_chip_read(onchip_mem_chip_read),
    .onchip_mem_addr(onchip_mem_addr),
    .onchip_mem_byte_enable(onchip_mem_byte_enable),
    .onchip_mem_write(onchip_mem_write),
    .onchip_mem_write_data(onchip_mem_write_data),
    .onchip_mem_read_data(onchip_mem_read_data),
    .cfg_mode(cfg_mode), .cfg_base_addr(cfg_base_addr),
    .cfg_pat_stride(cfg_pat_stride), .cfg_num_pat(cfg_num_pat),
    .frame_trig(frame_trig), .stop_req(stop_req), .frame_busy(frame_busy),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .de_in(de_in),
    .pix_data_out(pix_data_out), .h_sync_out(h_sync_out),
    .v_sync_out(v_sync_out), .de_out(de_out),
    .pat_idx(pat_idx), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Memory model: mem[i] = i * 0x01010101, word 0 overridden to 0x5; data one cycle after read.
  logic [MEM_DW-1:0] mem [2**MEM_AW];
  always @(posedge clk) begin
    if (onchip_mem_chip_read) onchip_mem_read_data <= mem[onchip_mem_addr];
  end

  logic [PIX_W-1:0] pix_q [$];
  always @(negedge clk) begin
    if (de_out) pix_q.push_back(pix_data_out);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trigger(input logic mode, input logic [MEM_AW-1:0] base,
                         input logic [MEM_AW-1:0] stride, input logic [4:0] np,
                         input logic with_stop);
    cfg_mode       = mode;
    cfg_base_addr  = base;
    cfg_pat_stride = stride;
    cfg_num_pat    = np;
    frame_trig     = 1'b1;
    stop_req       = with_stop;
    tick();
    frame_trig = 1'b0;
    stop_req   = 1'b0;
    repeat (10) tick();
  endtask

  // One frame: vsync pulse, then LINES lines of line_len de cycles, then blanking.
  task automatic run_frame(input int line_len, input bit chk_lat, input int stop_line);
    v_sync_in = 1'b1;
    tick();
    tick();
    v_sync_in = 1'b0;
    repeat (4) tick();
    for (int l = 0; l < LINES; l++) begin
      h_sync_in = 1'b1;
      tick();
      h_sync_in = 1'b0;
      tick();
      tick();
      for (int p = 0; p < line_len; p++) begin
        de_in = 1'b1;
        if (l == stop_line && p == 0) begin
          stop_req      = 1'b1;
          frame_trig    = 1'b1;
          cfg_mode      = 1'b1;
          cfg_base_addr = 11'd100;
        end
        if (chk_lat && l == 0 && p == 0) check("de_lag_before", de_out, 1'b0);
        tick();
        if (chk_lat && l == 0 && p == 0) check("de_lag_after", de_out, 1'b1);
        stop_req   = 1'b0;
        frame_trig = 1'b0;
      end
      de_in = 1'b0;
      tick();
    end
    repeat (12) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2**MEM_AW; i++) mem[i] = i * 32'h0101_0101;
    mem[0] = 32'h0000_0005;

    rst = 1'b1;
    cfg_mode = 1'b0; cfg_base_addr = '0; cfg_pat_stride = '0; cfg_num_pat = '0;
    frame_trig = 1'b0; stop_req = 1'b0;
    h_sync_in = 1'b0; v_sync_in = 1'b0; de_in = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_pix", pix_data_out, 24'h0);
    check("rst_de", de_out, 1'b0);
    check("rst_busy", frame_busy, 1'b0);
    check("rst_pat_idx", pat_idx, 4'd0);
    check("rst_underflow", underflow, 1'b0);
    check("rst_read", onchip_mem_chip_read, 1'b0);
    check("rst_byte_en", onchip_mem_byte_enable, 4'hF);
    check("rst_write", onchip_mem_write, 1'b0);
    rst = 1'b0;
    tick();

    // Binary, base 0, one pattern: word 0 = 0x5, 16 used bits per line, tail discarded
    trigger(1'b0, 11'd0, 11'd0, 5'd1, 1'b0);
    check("bin_busy", frame_busy, 1'b1);
    pix_q.delete();
    run_frame(16, 1'b0, -1);
    check("bin_count", pix_q.size(), 64);
    check("bin_l0_p0", pix_q[0], 24'hFFFFFF);
    check("bin_l0_p1", pix_q[1], 24'h000000);
    check("bin_l0_p2", pix_q[2], 24'hFFFFFF);
    check("bin_l0_p3", pix_q[3], 24'h000000);
    check("bin_l1_p0", pix_q[16], 24'hFFFFFF);
    check("bin_l1_p8", pix_q[24], 24'hFFFFFF);
    check("bin_l3_p1", pix_q[49], 24'hFFFFFF);
    check("bin_l3_p2", pix_q[50], 24'h000000);
    check("bin_busy_end", frame_busy, 1'b0);

    // Gray, base 8: 4 words per line, byte replicated, de delayed one cycle
    trigger(1'b1, 11'd8, 11'd0, 5'd1, 1'b0);
    pix_q.delete();
    run_frame(16, 1'b1, -1);
    check("gray_l0_p0", pix_q[0], 24'h080808);
    check("gray_l0_p4", pix_q[4], 24'h090909);
    check("gray_l3_p15", pix_q[63], 24'h171717);
    check("gray_underflow", underflow, 1'b0);
    check("gray_busy_end", frame_busy, 1'b0);

    // Three patterns, stride 16, base 2040: addresses wrap modulo 2048
    trigger(1'b1, 11'd2040, 11'd16, 5'd3, 1'b0);
    check("seq_idx0", pat_idx, 4'd0);
    pix_q.delete();
    run_frame(16, 1'b0, -1);
    check("seq_f0_p0", pix_q[0], 24'hF8F8F8);
    check("seq_f0_w2047", pix_q[28], 24'hFFFFFF);
    check("seq_f0_wrap_b0", pix_q[32], 24'h050505);
    check("seq_f0_wrap_b1", pix_q[33], 24'h000000);
    check("seq_idx1", pat_idx, 4'd1);
    check("seq_busy1", frame_busy, 1'b1);
    pix_q.delete();
    run_frame(16, 1'b0, -1);
    check("seq_f1_p0", pix_q[0], 24'h080808);
    check("seq_idx2", pat_idx, 4'd2);
    check("seq_busy2", frame_busy, 1'b1);
    pix_q.delete();
    run_frame(16, 1'b0, -1);
    check("seq_f2_p0", pix_q[0], 24'h181818);
    check("seq_f2_last", pix_q[63], 24'h272727);
    check("seq_idx_end", pat_idx, 4'd2);
    check("seq_busy_end", frame_busy, 1'b0);

    // Over-long first line outruns the 16 words fetched for the frame
    trigger(1'b1, 11'd8, 11'd0, 5'd1, 1'b0);
    pix_q.delete();
    run_frame(72, 1'b0, -1);
    check("uf_p0", pix_q[0], 24'h080808);
    check("uf_p63", pix_q[63], 24'h171717);
    check("uf_p64", pix_q[64], 24'h000000);
    check("uf_p100", pix_q[100], 24'h000000);
    check("uf_flag", underflow, 1'b1);
    trigger(1'b1, 11'd8, 11'd0, 5'd1, 1'b0);
    check("uf_cleared", underflow, 1'b0);
    pix_q.delete();
    run_frame(16, 1'b0, -1);
    check("uf_replay_p0", pix_q[0], 24'h080808);
    check("uf_replay_p63", pix_q[63], 24'h171717);
    check("uf_still_clear", underflow, 1'b0);

    // Stop mid-frame 0 of 4, with a trigger (new cfg) while busy that must be ignored
    trigger(1'b0, 11'd0, 11'd1, 5'd4, 1'b0);
    pix_q.delete();
    run_frame(16, 1'b0, 1);
    check("stop_l2_p0", pix_q[32], 24'h000000);
    check("stop_l2_p1", pix_q[33], 24'hFFFFFF);
    check("stop_busy", frame_busy, 1'b0);
    check("stop_idx", pat_idx, 4'd0);

    // Stop together with trigger in IDLE is ignored; then reset mid-line in frame 1
    trigger(1'b0, 11'd0, 11'd1, 5'd2, 1'b1);
    run_frame(16, 1'b0, -1);
    check("trigstop_busy", frame_busy, 1'b1);
    check("trigstop_idx", pat_idx, 4'd1);
    v_sync_in = 1'b1;
    tick();
    tick();
    v_sync_in = 1'b0;
    repeat (4) tick();
    h_sync_in = 1'b1;
    de_in     = 1'b1;
    repeat (5) tick();
    check("pre_rst_de", de_out, 1'b1);
    rst = 1'b1;
    tick();
    check("mid_rst_pix", pix_data_out, 24'h0);
    check("mid_rst_de", de_out, 1'b0);
    check("mid_rst_hs", h_sync_out, 1'b0);
    check("mid_rst_busy", frame_busy, 1'b0);
    check("mid_rst_idx", pat_idx, 4'd0);
    check("mid_rst_read", onchip_mem_chip_read, 1'b0);
    check("mid_rst_sel", onchip_mem_chip_select, 1'b0);
    check("mid_rst_addr", onchip_mem_addr, 11'd0);
    rst       = 1'b0;
    de_in     = 1'b0;
    h_sync_in = 1'b0;
    repeat (3) tick();
    trigger(1'b0, 11'd0, 11'd0, 5'd1, 1'b0);
    pix_q.delete();
    run_frame(16, 1'b0, -1);
    check("replay_p0", pix_q[0], 24'hFFFFFF);
    check("replay_p1", pix_q[1], 24'h000000);
    check("replay_p2", pix_q[2], 24'hFFFFFF);
    check("replay_busy", frame_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
